// File: rtl/pim_wb_scheduler.sv
// -----------------------------------------------------------------------------
// pim_wb_scheduler
//
// Shares the single register-file write port between the in-order pipeline WB
// stage and out-of-band PIM responses. PIM responses return in issue order but
// an arbitrary number of cycles after issue. A scoreboard tracks destination
// registers that still have a PIM write pending, and decode is stalled on
// RAW/WAW hazards against them, when PIM capacity is exhausted, and while the
// response buffer is being force-drained after starvation.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   id_*                 decode-stage instruction (valid, opcode, rs1, rs2, rd)
//   id_stall_o           hold IF/ID and inject a bubble into EX
//   pim_issue_i/_rd_i    PIM op leaving EX and its destination register
//   pim_busy_o           outstanding PIM ops == PIM_DEPTH
//   pim_rsp_*            PIM response handshake (valid/data/ready)
//   wb_*                 pipeline WB write request
//   rf_*                 register-file write port
//   pim_err_o            sticky: response accepted with no op outstanding
// -----------------------------------------------------------------------------
module pim_wb_scheduler #(
   parameter int         XLEN         = 32,
   parameter int         PIM_DEPTH    = 2,
   parameter int         BUF_DEPTH    = 2,
   parameter int         STARVE_LIMIT = 8,
   parameter logic [6:0] PIM_OPCODE   = 7'b0001011
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            id_valid_i,
   input  logic [6:0]      id_opcode_i,
   input  logic [4:0]      id_rs1_i,
   input  logic [4:0]      id_rs2_i,
   input  logic [4:0]      id_rd_i,
   output logic            id_stall_o,
   input  logic            pim_issue_i,
   input  logic [4:0]      pim_issue_rd_i,
   output logic            pim_busy_o,
   input  logic            pim_rsp_valid_i,
   input  logic [XLEN-1:0] pim_rsp_data_i,
   output logic            pim_rsp_ready_o,
   input  logic            wb_reg_write_i,
   input  logic [4:0]      wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic            rf_we_o,
   output logic [4:0]      rf_waddr_o,
   output logic [XLEN-1:0] rf_wdata_o,
   output logic            pim_err_o
);

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam int TAG_AW    = (PIM_DEPTH > 1) ? $clog2(PIM_DEPTH) : 1;
   localparam int TAG_CW    = $clog2(PIM_DEPTH + 1);
   localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int BUF_CW    = $clog2(BUF_DEPTH + 1);
   localparam int STARVE_CW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic {
      ST_NORMAL,
      ST_DRAIN
   } state_t;

   state_t              state;
   state_t              state_next;
   logic                drain_stall;

   logic [31:0]         sb;

   logic [4:0]          tag_mem [PIM_DEPTH];
   logic [TAG_AW-1:0]   tag_rptr;
   logic [TAG_AW-1:0]   tag_wptr;
   logic [TAG_CW-1:0]   tag_cnt;

   logic [4:0]          buf_rd   [BUF_DEPTH];
   logic [XLEN-1:0]     buf_data [BUF_DEPTH];
   logic [BUF_AW-1:0]   buf_rptr;
   logic [BUF_AW-1:0]   buf_wptr;
   logic [BUF_CW-1:0]   buf_cnt;

   logic [TAG_CW-1:0]   outstanding;
   logic [STARVE_CW-1:0] starve_cnt;

   logic                buf_empty;
   logic                buf_full;
   logic                tag_empty;
   logic                rsp_accept;
   logic                rsp_push;
   logic                rsp_orphan;
   logic                pipe_wins;
   logic                head_pop;
   logic [4:0]          head_rd;
   logic [XLEN-1:0]     head_data;

   logic                rs1_used;
   logic                rs2_used;
   logic                rd_written;

   // Handshake and arbitration terms shared by the datapath and the state.
   always_comb begin
      buf_empty  = (buf_cnt == '0);
      buf_full   = (buf_cnt == BUF_CW'(BUF_DEPTH));
      tag_empty  = (tag_cnt == '0);
      rsp_accept = pim_rsp_valid_i & ~buf_full;
      // A response with no tag to pair with is swallowed and flagged.
      rsp_push   = rsp_accept & ~tag_empty;
      rsp_orphan = rsp_accept & tag_empty;
      pipe_wins  = wb_reg_write_i && (wb_rd_i != 5'd0);
      head_pop   = ~pipe_wins & ~buf_empty;
      head_rd    = buf_rd[buf_rptr];
      head_data  = buf_data[buf_rptr];
   end

   assign pim_rsp_ready_o = ~buf_full;
   assign pim_busy_o      = (outstanding == TAG_CW'(PIM_DEPTH));

   // Write-port mux: a head popped with rd==0 just retires its slot.
   always_comb begin
      rf_we_o    = 1'b0;
      rf_waddr_o = wb_rd_i;
      rf_wdata_o = wb_data_i;
      if (pipe_wins) begin
         rf_we_o = 1'b1;
      end else if (head_pop && (head_rd != 5'd0)) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = head_rd;
         rf_wdata_o = head_data;
      end
   end

   // Which register fields the decode instruction really uses.
   always_comb begin
      rs1_used   = !((id_opcode_i == OPC_JAL) || (id_opcode_i == OPC_LUI) ||
                     (id_opcode_i == OPC_AUIPC));
      rs2_used   = (id_opcode_i == OPC_R) || (id_opcode_i == OPC_STORE) ||
                   (id_opcode_i == OPC_BRANCH) || (id_opcode_i == PIM_OPCODE);
      rd_written = !((id_opcode_i == OPC_STORE) || (id_opcode_i == OPC_BRANCH));
   end

   always_comb begin
      id_stall_o = id_valid_i &
                   ((rs1_used & sb[id_rs1_i]) |
                    (rs2_used & sb[id_rs2_i]) |
                    (rd_written & sb[id_rd_i]) |
                    ((id_opcode_i == PIM_OPCODE) & pim_busy_o) |
                    drain_stall);
   end

   // In-order tag FIFO: responses come back in issue order, so the oldest tag
   // names the destination of each arriving response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         tag_rptr <= '0;
         tag_wptr <= '0;
         tag_cnt  <= '0;
      end else begin
         if (pim_issue_i) begin
            tag_mem[tag_wptr] <= pim_issue_rd_i;
            tag_wptr <= (tag_wptr == TAG_AW'(PIM_DEPTH - 1)) ? '0 : tag_wptr + TAG_AW'(1);
         end
         if (rsp_push) begin
            tag_rptr <= (tag_rptr == TAG_AW'(PIM_DEPTH - 1)) ? '0 : tag_rptr + TAG_AW'(1);
         end
         case ({pim_issue_i, rsp_push})
            2'b10:   tag_cnt <= tag_cnt + TAG_CW'(1);
            2'b01:   tag_cnt <= tag_cnt - TAG_CW'(1);
            default: tag_cnt <= tag_cnt;
         endcase
      end
   end

   // Response buffer holding {rd,data} until the write port is free.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         buf_rptr <= '0;
         buf_wptr <= '0;
         buf_cnt  <= '0;
      end else begin
         if (rsp_push) begin
            buf_rd[buf_wptr]   <= tag_mem[tag_rptr];
            buf_data[buf_wptr] <= pim_rsp_data_i;
            buf_wptr <= (buf_wptr == BUF_AW'(BUF_DEPTH - 1)) ? '0 : buf_wptr + BUF_AW'(1);
         end
         if (head_pop) begin
            buf_rptr <= (buf_rptr == BUF_AW'(BUF_DEPTH - 1)) ? '0 : buf_rptr + BUF_AW'(1);
         end
         case ({rsp_push, head_pop})
            2'b10:   buf_cnt <= buf_cnt + BUF_CW'(1);
            2'b01:   buf_cnt <= buf_cnt - BUF_CW'(1);
            default: buf_cnt <= buf_cnt;
         endcase
      end
   end

   // An op stays outstanding until its result leaves the buffer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outstanding <= '0;
      end else begin
         case ({pim_issue_i, head_pop})
            2'b10:   outstanding <= outstanding + TAG_CW'(1);
            2'b01:   outstanding <= outstanding - TAG_CW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // The set is written after the clear so a same-cycle set wins.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sb <= '0;
      end else begin
         if (head_pop) begin
            sb[head_rd] <= 1'b0;
         end
         if (pim_issue_i && (pim_issue_rd_i != 5'd0)) begin
            sb[pim_issue_rd_i] <= 1'b1;
         end
      end
   end

   // A waiting head that is not popped always lost to the pipeline. The
   // counter saturates; values beyond the limit are never observed in NORMAL.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         starve_cnt <= '0;
      end else if (buf_empty || head_pop) begin
         starve_cnt <= '0;
      end else if (starve_cnt != STARVE_CW'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + STARVE_CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pim_err_o <= 1'b0;
      end else if (rsp_orphan) begin
         pim_err_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ST_NORMAL;
      end else begin
         state <= state_next;
      end
   end

   // Exit from DRAIN looks at the registered buffer count, so it lags the
   // final pop by one cycle.
   always_comb begin
      state_next = state;
      case (state)
         ST_NORMAL: if (starve_cnt == STARVE_CW'(STARVE_LIMIT)) state_next = ST_DRAIN;
         ST_DRAIN:  if (buf_empty) state_next = ST_NORMAL;
         default:   state_next = ST_NORMAL;
      endcase
   end

   always_comb begin
      drain_stall = (state == ST_DRAIN);
   end

endmodule
